// File: rtl/load_store_unit.sv
// Multicycle RV32I/RV64I load/store unit: effective-address generation, alignment
// check, request/grant memory port and byte-lane aligned, extended load results.
module load_store_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     base,
    input  logic [11:0]         offset,
    input  logic [XLEN-1:0]     store_data,
    output logic                busy,
    output logic                done,
    output logic                misaligned,
    output logic [XLEN-1:0]     load_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned LANE_W = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, DONE} state_t;
    state_t state, state_n;

    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   base_q, store_data_q;
    logic [11:0]       offset_q;

    logic              busy_n, done_n, misaligned_n, mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [XLEN-1:0]   mem_wdata_n, load_data_n;
    logic [STRB_W-1:0] mem_wstrb_n;

    logic [XLEN-1:0]   ea_full, rshift;
    logic [ADDR_W-1:0] ea;
    logic [LANE_W-1:0] lane;
    logic [3:0]        size_m1;
    logic [7:0]        mask8;
    logic [63:0]       rshift64, ext64;
    logic              illegal, reject, sext;

    // Address, legality and lane datapath; all operands come from the latched request.
    always_comb begin
        ea_full  = base_q + {{(XLEN-12){offset_q[11]}}, offset_q};
        ea       = ADDR_W'(ea_full);
        lane     = ea[LANE_W-1:0];
        size_m1  = (4'd1 << funct3_q[1:0]) - 4'd1;
        illegal  = (funct3_q == 3'b111) || (is_store_q && funct3_q[2]) ||
                   ((XLEN == 32) && (funct3_q == 3'b011 || funct3_q == 3'b110));
        reject   = illegal || (|(ea[2:0] & size_m1[2:0]));
        sext     = ~funct3_q[2];
        rshift   = mem_rdata >> {lane, 3'b000};
        rshift64 = 64'(rshift);
        case (funct3_q[1:0])
            2'b00:   begin mask8 = 8'h01; ext64 = {{56{sext & rshift64[7]}},  rshift64[7:0]};  end
            2'b01:   begin mask8 = 8'h03; ext64 = {{48{sext & rshift64[15]}}, rshift64[15:0]}; end
            2'b10:   begin mask8 = 8'h0f; ext64 = {{32{sext & rshift64[31]}}, rshift64[31:0]}; end
            default: begin mask8 = 8'hff; ext64 = rshift64;                                    end
        endcase
    end

    always_comb begin
        state_n      = state;
        busy_n       = busy;
        done_n       = 1'b0;
        misaligned_n = 1'b0;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_wstrb_n  = mem_wstrb;
        load_data_n  = load_data;
        case (state)
            IDLE: if (start) begin
                state_n = ADDR;
                busy_n  = 1'b1;
            end
            ADDR: if (reject) begin
                state_n      = DONE;
                busy_n       = 1'b0;
                done_n       = 1'b1;
                misaligned_n = 1'b1;
                if (!is_store_q) load_data_n = '0;
            end else begin
                state_n     = REQ;
                mem_req_n   = 1'b1;
                mem_we_n    = is_store_q;
                mem_addr_n  = {ea[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                mem_wdata_n = is_store_q ? (store_data_q << {lane, 3'b000}) : '0;
                mem_wstrb_n = is_store_q ? (STRB_W'(mask8) << lane) : '0;
            end
            REQ: if (mem_gnt) begin
                mem_req_n   = 1'b0;
                mem_we_n    = 1'b0;
                mem_wstrb_n = '0;
                if (is_store_q) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: if (mem_rvalid) begin
                load_data_n = ext64[XLEN-1:0];
                state_n     = DONE;
                busy_n      = 1'b0;
                done_n      = 1'b1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            misaligned   <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            load_data    <= '0;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            base_q       <= '0;
            offset_q     <= '0;
            store_data_q <= '0;
        end else begin
            state      <= state_n;
            busy       <= busy_n;
            done       <= done_n;
            misaligned <= misaligned_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_wstrb  <= mem_wstrb_n;
            load_data  <= load_data_n;
            if (state == IDLE && start) begin
                is_store_q   <= is_store;
                funct3_q     <= funct3;
                base_q       <= base;
                offset_q     <= offset;
                store_data_q <= store_data;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// against a byte-arithmetic reference model and a reactive memory responder.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0, start = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [63:0] base = '0, store_data = '0, mem_rdata = '0;
    logic [11:0] offset = '0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic        busy, done, misaligned, mem_req, mem_we;
    logic [63:0] load_data, mem_wdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wstrb;

    int          checks = 0, errors = 0;
    logic [63:0] ld_model = '0;

    load_store_unit #(.XLEN(64), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data), .busy(busy), .done(done),
        .misaligned(misaligned), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: treats memory as bytes and computes results with plain arithmetic.
    function automatic void model(input logic st, input logic [2:0] f, input logic [63:0] b,
                                  input logic [11:0] off, input logic [63:0] sd, input logic [63:0] rd,
                                  output logic rej, output logic [31:0] addr, output logic [63:0] wd,
                                  output logic [7:0] strb, output logic [63:0] ld);
        logic [63:0]  sum;
        logic [31:0]  ea;
        int unsigned  size, lane;
        logic [127:0] wide, mask, val;
        sum  = b + {{52{off[11]}}, off};
        ea   = sum[31:0];
        size = 1 << f[1:0];
        lane = ea % 8;
        rej  = (f == 3'b111) || (st && f >= 3'd4) || (ea % size != 0);
        addr = ea - lane;
        wide = {64'b0, sd} << (8 * lane);
        wd   = wide[63:0];
        strb = 8'(((1 << size) - 1) << lane);
        mask = (128'd1 << (8 * size)) - 128'd1;
        val  = ({64'b0, rd} >> (8 * lane)) & mask;
        if (f < 3'd4 && val[8*size-1]) val = val | ~mask;
        ld   = val[63:0];
    endfunction

    task automatic run_access(input string name, input logic st, input logic [2:0] f,
                              input logic [63:0] b, input logic [11:0] off, input logic [63:0] sd,
                              input logic [63:0] rd, input int gstall, input int rdly, input int pulse_cyc,
                              output int done_cyc, output logic [31:0] o_addr, output logic [7:0] o_strb,
                              output logic [63:0] o_wdata, output logic [63:0] o_ld);
        logic        rej, o_we, granted, prev_req, got, unstable;
        logic [31:0] e_addr;
        logic [63:0] e_wd, e_ld;
        logic [7:0]  e_strb;
        int          exp_done, cyc, grant_cyc, req_edges, stall_left;
        model(st, f, b, off, sd, rd, rej, e_addr, e_wd, e_strb, e_ld);
        exp_done = rej ? 2 : (st ? 3 + gstall : 4 + gstall + rdly);
        if (!st) ld_model = rej ? 64'd0 : e_ld;
        is_store = st; funct3 = f; base = b; offset = off; store_data = sd; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_c1 got %b want 1", name, busy); end
        done_cyc = -1; granted = 0; prev_req = 0; got = 0; unstable = 0; req_edges = 0;
        grant_cyc = 0; stall_left = gstall; o_we = 0;
        o_addr = '0; o_strb = '0; o_wdata = '0; o_ld = '0;
        for (int k = 0; k < 64; k++) begin
            if (done === 1'b1) begin done_cyc = cyc; break; end
            start = (cyc == pulse_cyc);
            if (start) base = {$urandom, $urandom};
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            if (mem_req === 1'b1) begin
                if (!prev_req) req_edges++;
                if (!got) begin
                    got = 1; o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata; o_we = mem_we;
                end else if ({mem_addr, mem_wstrb, mem_wdata, mem_we} !== {o_addr, o_strb, o_wdata, o_we}) begin
                    unstable = 1;
                end
                mem_rvalid = 1'($urandom_range(0, 1));
                if (stall_left == 0) begin mem_gnt = 1'b1; granted = 1; grant_cyc = cyc; end
                else stall_left--;
            end else if (granted && !st && cyc >= grant_cyc + 1 + rdly) begin
                mem_rvalid = 1'b1; mem_rdata = rd;
            end
            prev_req = (mem_req === 1'b1);
            tick();
            cyc++;
        end
        start = 1'b0;
        o_ld = load_data;
        checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_done); end
        checks++; if (misaligned !== rej) begin errors++; $display("FAIL %s misaligned got %b want %b", name, misaligned, rej); end
        checks++; if (load_data !== ld_model) begin errors++; $display("FAIL %s load_data got %h want %h", name, load_data, ld_model); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s req_at_done got %b want 0", name, mem_req); end
        if (rej) begin
            checks++; if (req_edges != 0) begin errors++; $display("FAIL %s req_count got %0d want 0", name, req_edges); end
        end else begin
            checks++; if (req_edges != 1) begin errors++; $display("FAIL %s req_count got %0d want 1", name, req_edges); end
            checks++; if (unstable) begin errors++; $display("FAIL %s req_stable got unstable want stable", name); end
            checks++; if (o_addr !== e_addr) begin errors++; $display("FAIL %s mem_addr got %h want %h", name, o_addr, e_addr); end
            checks++; if (o_we !== st) begin errors++; $display("FAIL %s mem_we got %b want %b", name, o_we, st); end
            checks++; if (o_strb !== (st ? e_strb : 8'h00)) begin errors++; $display("FAIL %s mem_wstrb got %h want %h", name, o_strb, st ? e_strb : 8'h00); end
            if (st) begin
                checks++; if (o_wdata !== e_wd) begin errors++; $display("FAIL %s mem_wdata got %h want %h", name, o_wdata, e_wd); end
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
        checks++; if ({done, busy, mem_req} !== 3'b000) begin errors++; $display("FAIL %s after_done got %b want 000", name, {done, busy, mem_req}); end
    endtask

    task automatic test_reset();
        int d; logic [31:0] a; logic [7:0] s; logic [63:0] w, l;
        rst = 1'b1; tick(); tick();
        checks++; if ({busy, done, misaligned, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, load_data} !== '0) begin
            errors++; $display("FAIL reset_values got %b%b%b%b%b %h %h %h %h want all 0", busy, done, misaligned, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, load_data);
        end
        rst = 1'b0; tick();
        is_store = 1'b0; funct3 = 3'b011; base = 64'h200; offset = 12'h0; start = 1'b1;
        tick(); start = 1'b0; tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_pending_req got %b want 1", mem_req); end
        rst = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hdeadbeefcafef00d;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({busy, done, misaligned, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, load_data} !== '0) begin
                errors++; $display("FAIL reset_abort_%0d got nonzero outputs req=%b done=%b addr=%h want all 0", i, mem_req, done, mem_addr);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin mem_gnt = 1'b0; mem_rvalid = 1'b0; end
            checks++; if ({done, mem_req, busy} !== 3'b000) begin errors++; $display("FAIL reset_no_done_%0d got %b want 000", i, {done, mem_req, busy}); end
        end
        ld_model = '0;
        run_access("post_reset_ld", 1'b0, 3'b011, 64'h100, 12'h008, 64'h0, 64'h0102030405060708, 0, 0, 0, d, a, s, w, l);
        checks++; if (l !== 64'h0102030405060708) begin errors++; $display("FAIL post_reset_ld value got %h want 0102030405060708", l); end
    endtask

    task automatic test_ld();
        int d; logic [31:0] a; logic [7:0] s; logic [63:0] w, l;
        run_access("ld", 1'b0, 3'b011, 64'h100, 12'h008, 64'h0, 64'h1122334455667788, 0, 0, 0, d, a, s, w, l);
        checks++; if (a !== 32'h108 || s !== 8'h00) begin errors++; $display("FAIL ld_addr got %h/%h want 108/00", a, s); end
        checks++; if (d != 4) begin errors++; $display("FAIL ld_latency got %0d want 4", d); end
        checks++; if (l !== 64'h1122334455667788) begin errors++; $display("FAIL ld_value got %h want 1122334455667788", l); end
    endtask

    task automatic test_lb_lbu();
        int d; logic [31:0] a; logic [7:0] s; logic [63:0] w, l;
        run_access("lb", 1'b0, 3'b000, 64'h100, 12'h003, 64'h0, 64'h0000000080000000, 0, 0, 0, d, a, s, w, l);
        checks++; if (l !== 64'hFFFFFFFFFFFFFF80 || a !== 32'h100) begin errors++; $display("FAIL lb got %h @%h want FFFFFFFFFFFFFF80 @100", l, a); end
        run_access("lbu", 1'b0, 3'b100, 64'h100, 12'h003, 64'h0, 64'h0000000080000000, 0, 0, 0, d, a, s, w, l);
        checks++; if (l !== 64'h0000000000000080 || a !== 32'h100) begin errors++; $display("FAIL lbu got %h @%h want 0000000000000080 @100", l, a); end
    endtask

    task automatic test_sh_negative();
        int d; logic [31:0] a; logic [7:0] s; logic [63:0] w, l;
        run_access("sh_neg", 1'b1, 3'b001, 64'h112, 12'hFF8, 64'hBEEF, 64'h0, 0, 0, 0, d, a, s, w, l);
        checks++; if (a !== 32'h108 || s !== 8'h0C || w[31:16] !== 16'hBEEF || d != 3) begin
            errors++; $display("FAIL sh_neg got addr=%h strb=%h wdata=%h done=%0d want 108/0C/BEEF/3", a, s, w[31:16], d);
        end
        checks++; if (l !== 64'h80) begin errors++; $display("FAIL sh_keeps_load_data got %h want 80", l); end
    endtask

    task automatic test_misaligned();
        int d; logic [31:0] a; logic [7:0] s; logic [63:0] w, l;
        run_access("lw_misaligned", 1'b0, 3'b010, 64'h100, 12'h002, 64'h0, 64'h0, 0, 0, 0, d, a, s, w, l);
        checks++; if (d != 2 || l !== 64'h0) begin errors++; $display("FAIL lw_misaligned got done=%0d ld=%h want 2/0", d, l); end
        run_access("funct3_111", 1'b0, 3'b111, 64'h100, 12'h000, 64'h0, 64'h0, 0, 0, 0, d, a, s, w, l);
        checks++; if (d != 2) begin errors++; $display("FAIL funct3_111 done got %0d want 2", d); end
    endtask

    task automatic test_backpressure();
        int d; logic [31:0] a; logic [7:0] s; logic [63:0] w, l;
        run_access("backpressure", 1'b1, 3'b011, 64'h300, 12'h010, 64'h0123456789ABCDEF, 64'h0, 3, 0, 3, d, a, s, w, l);
        checks++; if (d != 6 || a !== 32'h310 || s !== 8'hFF) begin errors++; $display("FAIL backpressure got done=%0d addr=%h strb=%h want 6/310/FF", d, a, s); end
    endtask

    task automatic test_random();
        int d; logic [31:0] a; logic [7:0] s; logic [63:0] w, l;
        logic [63:0] b; logic [11:0] o;
        for (int i = 0; i < 80; i++) begin
            b = {$urandom, $urandom};
            o = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin b[2:0] = 3'b000; o[2:0] = 3'b000; end
            run_access("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), b, o,
                       {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 8)), d, a, s, w, l);
        end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_lb_lbu();
        test_sh_negative();
        test_misaligned();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised multicycle load/store unit for the RV64I/RV32I memory datapath. It sits between the register file/immediate path and the data memory. It computes the effective address (rs1 + sign-extended 12-bit offset), checks alignment, and issues one request per access on a request/grant memory port with variable latency. Results are byte-lane aligned, with byte/half/word/double sign or zero extension.

## Interface
Parameters:
- XLEN, 64, data width; legal values 32 or 64.
- ADDR_W, 32, memory address width; effective address is truncated to ADDR_W.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width/sign code (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu).
- base  in  XLEN  rs1 value.
- offset  in  12  raw I/S-type immediate.
- store_data  in  XLEN  rs2 value.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid with done; access rejected.
- load_data  out  XLEN  extended load result; holds until the next load completes.
- mem_req  out  1  request valid.
- mem_we  out  1  write enable; qualified by mem_req.
- mem_addr  out  ADDR_W  XLEN/8-aligned address.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  XLEN/8  byte strobes; all 0 for loads.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  full aligned read word.

## Operation
- FSM states: IDLE, ADDR, REQ, WAIT, DONE.
- **IDLE:** if start=1, latch is_store, funct3, base, offset and store_data, then go to ADDR.
- **ADDR:**
  - ea = base + sext(offset), modulo 2^ADDR_W; lane = ea[log2(XLEN/8)-1:0]; size = 1, 2, 4 or 8 bytes.
  - Reject the access if ea is not size-aligned, or if funct3 is illegal. Illegal codes: 111 always; 011 and 110 when XLEN=32; 100–110 for stores.
  - On reject: go to DONE with misaligned=1 and no memory request. Otherwise go to REQ.
- **REQ:**
  - Drive mem_req=1, mem_addr = ea with lane bits cleared, and mem_we = is_store.
  - For stores: mem_wdata = store_data << (8·lane); mem_wstrb = ((1<<size)−1) << lane.
  - Hold all request outputs stable until mem_gnt=1.
  - On grant, a store goes to DONE and a load goes to WAIT.
- **WAIT:**
  - Wait for mem_rvalid; mem_rvalid is ignored in REQ.
  - On mem_rvalid: shift rdata right by 8·lane, take the low size bytes, and sign- or zero-extend to XLEN. Register the result into load_data, then go to DONE.
- **DONE:** done=1 for one cycle, then go to IDLE.
- start while busy is ignored; it is not queued.
- A rejected load clears load_data to 0.
- A store never modifies load_data.

## Timing
- Reset values: state IDLE, and busy, done, misaligned, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata and load_data all 0.
- Cycle numbering: start is sampled at edge 0.
  - ADDR occupies cycle 1.
  - REQ occupies cycle 2 or later.
- Store with immediate grant: done is high in cycle 3 (3-cycle latency). Each cycle of grant stall adds one cycle.
- Load with immediate grant and rvalid one cycle later: done in cycle 4. Each cycle of rvalid delay adds one cycle.
- Rejected access: done and misaligned are high in cycle 2; mem_req never rises.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rst in any state returns the unit to IDLE and clears all outputs at that edge. After reset:
  - mem_req is low in the next cycle.
  - A pending grant or rvalid is ignored.
  - No done pulse is produced for the aborted access.
- busy and done are never high in the same cycle as mem_req for a new access. The next start is accepted in the cycle after done.

## Test plan
- **Reset:** hold rst=1 for 2 cycles during a pending REQ → all outputs 0 and no done pulse; a new ld started afterwards completes normally.
- **ld:** base=0x100, offset=0x008, gnt immediate, rdata=0x1122334455667788 one cycle after grant → mem_addr=0x108, mem_wstrb=0x00, done in cycle 4, load_data=0x1122334455667788.
- **lb/lbu:** base=0x100, offset=0x003, rdata=0x0000000080000000 →
  - lb gives load_data=0xFFFFFFFFFFFFFF80;
  - repeated with lbu gives 0x0000000000000080;
  - mem_addr=0x100 in both cases.
- **sh with negative offset:** base=0x112, offset=0xFF8 (ea=0x10A), store_data=0xBEEF → mem_addr=0x108, mem_wstrb=0x0C, mem_wdata[31:16]=0xBEEF, mem_we=1, done in cycle 3 with grant in cycle 2.
- **Misaligned:** lw with ea=0x102 → no mem_req, done=1 and misaligned=1 in cycle 2. Then funct3=111 → same response.
- **Backpressure:** grant held low for 3 cycles with a second start pulsed during the stall →
  - request outputs stay stable throughout;
  - the second start is ignored;
  - done arrives in cycle 6 for the store;
  - exactly one mem_req transaction is seen.
